alu_sequencer: RTL

//  Control-side initiator for the accumulator ALU. Accepts one 8085 opcode byte per handshake.

---
 rtl/alu_sequencer_pkg.sv | 89 ++++++++
 rtl/alu_sequencer_if.sv | 42 ++++
 rtl/alu_op_decode.sv | 55 +++++
 rtl/alu_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the accumulator-ALU sequencer: ALU opcodes, 8085
// register codes, FSM state codes and the decoder result record.
package alu_sequencer_pkg;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_ADC = 5'b00001;
    localparam logic [4:0] ALU_SUB = 5'b00010;
    localparam logic [4:0] ALU_SBB = 5'b00011;
    localparam logic [4:0] ALU_ANA = 5'b00100;
    localparam logic [4:0] ALU_XRA = 5'b00101;
    localparam logic [4:0] ALU_ORA = 5'b00110;
    localparam logic [4:0] ALU_CMP = 5'b00111;
    localparam logic [4:0] ALU_RLC = 5'b01000;
    localparam logic [4:0] ALU_RRC = 5'b01001;
    localparam logic [4:0] ALU_RAL = 5'b01010;
    localparam logic [4:0] ALU_RAR = 5'b01011;
    localparam logic [4:0] ALU_DAA = 5'b01100;
    localparam logic [4:0] ALU_CMA = 5'b01101;
    localparam logic [4:0] ALU_STC = 5'b01110;
    localparam logic [4:0] ALU_CMC = 5'b01111;
    localparam logic [4:0] ALU_INR = 5'b10000;
    localparam logic [4:0] ALU_DCR = 5'b10001;

    typedef enum logic [2:0] {
        REG_B = 3'd0,
        REG_C = 3'd1,
        REG_D = 3'd2,
        REG_E = 3'd3,
        REG_H = 3'd4,
        REG_L = 3'd5,
        REG_M = 3'd6,
        REG_A = 3'd7
    } reg_code_e;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_SAVE    = 3'd2;
    localparam logic [2:0] ST_LOADR   = 3'd3;
    localparam logic [2:0] ST_EXEC    = 3'd4;
    localparam logic [2:0] ST_WB      = 3'd5;
    localparam logic [2:0] ST_RESTORE = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    typedef enum logic [2:0] {
        CLS_ALU_REG,
        CLS_ALU_IMM,
        CLS_ACC,
        CLS_RMW,
        CLS_ILLEGAL
    } op_class_e;

    typedef struct packed {
        op_class_e  cls;
        logic [4:0] alu_op;
        reg_code_e  reg_sel;
        logic       illegal;
    } decode_t;

    function automatic logic [4:0] alu_arith_op(input logic [2:0] ooo);
        logic [4:0] op;
        case (ooo)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_ADC;
            3'd2:    op = ALU_SUB;
            3'd3:    op = ALU_SBB;
            3'd4:    op = ALU_ANA;
            3'd5:    op = ALU_XRA;
            3'd6:    op = ALU_ORA;
            default: op = ALU_CMP;
        endcase
        return op;
    endfunction

    function automatic logic [4:0] alu_acc_op(input logic [2:0] ooo);
        logic [4:0] op;
        case (ooo)
            3'd0:    op = ALU_RLC;
            3'd1:    op = ALU_RRC;
            3'd2:    op = ALU_RAL;
            3'd3:    op = ALU_RAR;
            3'd4:    op = ALU_DAA;
            3'd5:    op = ALU_CMA;
            3'd6:    op = ALU_STC;
            default: op = ALU_CMC;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Decoder handshake, register/memory bus and ALU strobe bundle of the sequencer.
interface alu_sequencer_if;

    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;

    logic       opnd_req;
    logic [2:0] opnd_sel;
    logic       opnd_imm;
    logic       opnd_ack;

    logic       wb_req;
    logic [2:0] wb_sel;
    logic       wb_ack;

    logic [4:0] alu_opcode;
    logic       alu_ctrl;
    logic       acc_write_en;
    logic       tmp_write_en;
    logic       act_store;
    logic       act_restore;
    logic       flags_write_en;

    logic       done;
    logic       err;

    modport master (
        input  instr_valid, instr, opnd_ack, wb_ack,
        output instr_ready, opnd_req, opnd_sel, opnd_imm, wb_req, wb_sel,
               alu_opcode, alu_ctrl, acc_write_en, tmp_write_en,
               act_store, act_restore, flags_write_en, done, err
    );

    modport slave (
        output instr_valid, instr, opnd_ack, wb_ack,
        input  instr_ready, opnd_req, opnd_sel, opnd_imm, wb_req, wb_sel,
               alu_opcode, alu_ctrl, acc_write_en, tmp_write_en,
               act_store, act_restore, flags_write_en, done, err
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational 8085 opcode classifier: instruction class, ALU opcode,
// source/destination register code and illegal flag.
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  logic [7:0] instr,
    output decode_t    dec
);

    logic [1:0] grp;
    logic [2:0] mid;
    logic [2:0] lo;

    assign grp = instr[7:6];
    assign mid = instr[5:3];
    assign lo  = instr[2:0];

    always_comb begin
        dec.cls     = CLS_ILLEGAL;
        dec.alu_op  = ALU_ADD;
        dec.reg_sel = REG_B;
        dec.illegal = 1'b1;
        case (grp)
            2'b10: begin
                dec.cls     = CLS_ALU_REG;
                dec.alu_op  = alu_arith_op(mid);
                dec.reg_sel = reg_code_e'(lo);
                dec.illegal = 1'b0;
            end
            2'b11: begin
                if (lo == 3'b110) begin
                    dec.cls     = CLS_ALU_IMM;
                    dec.alu_op  = alu_arith_op(mid);
                    dec.illegal = 1'b0;
                end
            end
            2'b00: begin
                if (lo == 3'b111 && mid != 3'b100) begin
                    dec.cls     = CLS_ACC;
                    dec.alu_op  = alu_acc_op(mid);
                    dec.illegal = 1'b0;
                end else if (lo == 3'b100 || lo == 3'b101) begin
                    // INR A / DCR A need no save/restore of the accumulator
                    dec.cls     = (reg_code_e'(mid) == REG_A) ? CLS_ACC : CLS_RMW;
                    dec.alu_op  = lo[0] ? ALU_DCR : ALU_INR;
                    dec.reg_sel = reg_code_e'(mid);
                    dec.illegal = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Control-side initiator for the accumulator ALU: accepts one opcode per
// handshake, fetches operands, pulses the ALU and writes results back.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)(
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    decode_t          dec;
    logic [2:0]       state_q, state_d;
    logic [4:0]       op_q, op_d;
    reg_code_e        sel_q, sel_d;
    logic             imm_q, imm_d;
    logic             rmw_q, rmw_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out;

    alu_op_decode u_dec (
        .instr (bus.instr),
        .dec   (dec)
    );

    // The limit is reached in the cycle the counter would step past CNT_LAST
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        imm_d   = imm_q;
        rmw_d   = rmw_q;
        err_d   = err_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    op_d  = dec.alu_op;
                    sel_d = dec.reg_sel;
                    imm_d = (dec.cls == CLS_ALU_IMM);
                    rmw_d = (dec.cls == CLS_RMW);
                    err_d = dec.illegal;
                    case (dec.cls)
                        CLS_ALU_REG, CLS_ALU_IMM: state_d = ST_FETCH;
                        CLS_ACC:                  state_d = ST_EXEC;
                        CLS_RMW:                  state_d = ST_SAVE;
                        default:                  state_d = ST_DONE;
                    endcase
                end
            end
            ST_FETCH: begin
                if (bus.opnd_ack) begin
                    state_d = ST_EXEC;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAVE: state_d = ST_LOADR;
            ST_LOADR: begin
                if (bus.opnd_ack) begin
                    state_d = ST_EXEC;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = ST_RESTORE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EXEC: state_d = rmw_q ? ST_WB : ST_DONE;
            ST_WB: begin
                if (bus.wb_ack) begin
                    state_d = ST_RESTORE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = ST_RESTORE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESTORE: state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            sel_q   <= REG_B;
            imm_q   <= 1'b0;
            rmw_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            imm_q   <= imm_d;
            rmw_q   <= rmw_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.instr_ready    = (state_q == ST_IDLE);
    assign bus.opnd_req       = (state_q == ST_FETCH) || (state_q == ST_LOADR);
    assign bus.opnd_sel       = (((state_q == ST_FETCH) && !imm_q) || (state_q == ST_LOADR))
                                ? sel_q : REG_B;
    assign bus.opnd_imm       = (state_q == ST_FETCH) && imm_q;
    assign bus.tmp_write_en   = (state_q == ST_FETCH) && bus.opnd_ack;
    assign bus.acc_write_en   = (state_q == ST_LOADR) && bus.opnd_ack;
    assign bus.act_store      = (state_q == ST_SAVE);
    assign bus.act_restore    = (state_q == ST_RESTORE);
    assign bus.alu_ctrl       = (state_q == ST_EXEC);
    assign bus.alu_opcode     = (state_q == ST_IDLE) ? '0 : op_q;
    assign bus.wb_req         = (state_q == ST_WB);
    assign bus.wb_sel         = (state_q == ST_WB) ? sel_q : REG_B;
    assign bus.flags_write_en = 1'b0;
    assign bus.done           = (state_q == ST_DONE);
    assign bus.err            = (state_q == ST_DONE) && err_q;

endmodule
